// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: opcode encodings
// driven by the control unit and the two-state run/halt encoding.
package pc_pkg;

   // Opcodes presented on flagPC each cycle
   localparam logic [2:0] PC_HOLD   = 3'd0;
   localparam logic [2:0] PC_INC    = 3'd1;
   localparam logic [2:0] PC_JUMP   = 3'd2;
   localparam logic [2:0] PC_BRANCH = 3'd3;
   localparam logic [2:0] PC_CALL   = 3'd4;
   localparam logic [2:0] PC_RET    = 3'd5;
   localparam logic [2:0] PC_HALT   = 3'd6;
   localparam logic [2:0] PC_RSVD   = 3'd7;

   // Sequencer state: fetching, or parked until an interrupt arrives
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_e;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO used by call, return and interrupt entry.
// The pointer counts occupied entries (0..STACK_DEPTH), so it carries one
// bit more than the entry index and full/empty decode straight from it.
// Push into a full stack and pop from an empty stack are ignored here;
// the parent decides whether such a request is an error.
module return_stack
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned    PTR_W   = $clog2(STACK_DEPTH) + 1;
   localparam int unsigned    IDX_W   = $clog2(STACK_DEPTH);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(STACK_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  ptr_d;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [IDX_W-1:0]  top_idx_s;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full_o     = (ptr_q == PTR_MAX);
   assign empty_o    = (ptr_q == {PTR_W{1'b0}});
   assign push_ok_s  = push_i & ~full_o;
   assign pop_ok_s   = pop_i & ~empty_o;
   assign wr_idx_s   = ptr_q[IDX_W-1:0];
   assign top_idx_s  = wr_idx_s - IDX_ONE;
   assign top_data_o = mem_q[top_idx_s];

   // Next occupancy: push has precedence, the parent never requests both
   always_comb begin
      ptr_d = ptr_q;
      if (push_ok_s) begin
         ptr_d = ptr_q + PTR_ONE;
      end else if (pop_ok_s) begin
         ptr_d = ptr_q - PTR_ONE;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Occupancy pointer; reset empties the stack
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q <= {PTR_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Entry storage; contents are don't-care after reset so no reset here
   always_ff @(posedge clock) begin
      if (push_ok_s && reset) begin
         mem_q[wr_idx_s] <= push_data_i;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Holds the PC, the run/halt state, the sticky
// stack error flag and the interrupt-entry pulse. Each cycle one action is
// chosen with priority stall > interrupt > opcode; all arithmetic on the PC
// wraps silently modulo 2^ADDR_W.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned RESET_ADDR  = 0,
   parameter int unsigned IRQ_VECTOR  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        flagPC,
   input  logic [ADDR_W-1:0] newAddress,
   input  logic [ADDR_W-1:0] offset,
   input  logic              stall,
   input  logic              irq,
   output logic              irqTaken,
   output logic [ADDR_W-1:0] address,
   output logic              halted,
   output logic              stackFull,
   output logic              stackEmpty,
   output logic              stackError
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_ADDR);
   localparam logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(IRQ_VECTOR);

   pc_state_e         state_q;
   pc_state_e         state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic              err_q;
   logic              err_d;
   logic              irq_taken_q;
   logic              irq_taken_d;

   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] push_data_s;
   logic [ADDR_W-1:0] top_data_s;
   logic              full_s;
   logic              empty_s;
   logic [ADDR_W-1:0] addr_inc_s;
   logic [ADDR_W-1:0] addr_branch_s;

   assign addr_inc_s    = addr_q + ADDR_ONE;
   assign addr_branch_s = addr_q + offset;

   return_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_return_stack (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push_s),
      .pop_i       (pop_s),
      .push_data_i (push_data_s),
      .top_data_o  (top_data_s),
      .full_o      (full_s),
      .empty_o     (empty_s)
   );

   // Next PC, state, error flag and stack requests for this cycle
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      err_d       = err_q;
      irq_taken_d = 1'b0;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      push_data_s = addr_inc_s;

      if (stall) begin
         // everything freezes, including a pending interrupt
         state_d = state_q;
      end else if (irq && !full_s) begin
         // in RUN the fetched instruction is discarded and re-executed on
         // return; in HALT the halt itself is skipped on return
         push_s      = 1'b1;
         push_data_s = (state_q == ST_HALT) ? addr_inc_s : addr_q;
         addr_d      = VEC_ADDR;
         state_d     = ST_RUN;
         irq_taken_d = 1'b1;
      end else if (state_q == ST_HALT) begin
         // opcodes are ignored while parked
         state_d = ST_HALT;
      end else begin
         case (flagPC)
            PC_HOLD: begin
               addr_d = addr_q;
            end
            PC_INC: begin
               addr_d = addr_inc_s;
            end
            PC_JUMP: begin
               addr_d = newAddress;
            end
            PC_BRANCH: begin
               addr_d = addr_branch_s;
            end
            PC_CALL: begin
               if (full_s) begin
                  err_d = 1'b1;
               end else begin
                  push_s      = 1'b1;
                  push_data_s = addr_inc_s;
                  addr_d      = newAddress;
               end
            end
            PC_RET: begin
               if (empty_s) begin
                  err_d = 1'b1;
               end else begin
                  pop_s  = 1'b1;
                  addr_d = top_data_s;
               end
            end
            PC_HALT: begin
               state_d = ST_HALT;
            end
            PC_RSVD: begin
               addr_d = addr_q;
            end
            default: begin
               addr_d = addr_q;
            end
         endcase
      end
   end

   // Sequencer registers with asynchronous clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         addr_q      <= RST_ADDR;
         err_q       <= 1'b0;
         irq_taken_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         irq_taken_q <= irq_taken_d;
      end
   end

   assign address    = addr_q;
   assign halted     = (state_q == ST_HALT);
   assign stackFull  = full_s;
   assign stackEmpty = empty_s;
   assign stackError = err_q;
   assign irqTaken   = irq_taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Two instances: the default 20-bit/8-deep
// configuration and a 4-bit/2-deep one for wrap and stack-limit cases.
// A behavioural model produces expected outputs that are queued when
// stimulus is driven and popped and compared after the clock edge.
module tb_pc_sequencer;

   logic        clock;
   logic        reset;

   logic [2:0]  op0, op1;
   logic [19:0] na0, of0;
   logic [3:0]  na1, of1;
   logic        stl0, stl1, irq0, irq1;

   logic [19:0] addr0;
   logic [3:0]  addr1;
   logic [1:0]  halted, sfull, sempty, serr, irqt;

   pc_sequencer u_big (
      .clock(clock), .reset(reset), .flagPC(op0), .newAddress(na0),
      .offset(of0), .stall(stl0), .irq(irq0), .irqTaken(irqt[0]),
      .address(addr0), .halted(halted[0]), .stackFull(sfull[0]),
      .stackEmpty(sempty[0]), .stackError(serr[0])
   );

   pc_sequencer #(.ADDR_W(4), .STACK_DEPTH(2), .RESET_ADDR(0), .IRQ_VECTOR(8)) u_small (
      .clock(clock), .reset(reset), .flagPC(op1), .newAddress(na1),
      .offset(of1), .stall(stl1), .irq(irq1), .irqTaken(irqt[1]),
      .address(addr1), .halted(halted[1]), .stackFull(sfull[1]),
      .stackEmpty(sempty[1]), .stackError(serr[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          sel;
      int unsigned addr;
      bit          halted;
      bit          full;
      bit          empty;
      bit          err;
      bit          irqt;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   // model state per instance
   int unsigned m_addr [2];
   bit          m_halt [2];
   bit          m_err  [2];
   bit          m_irqt [2];
   int unsigned stk0[$];
   int unsigned stk1[$];

   function automatic int unsigned msk(int s);
      return (s == 0) ? 32'h000F_FFFF : 32'h0000_000F;
   endfunction
   function automatic int dep(int s);
      return (s == 0) ? 8 : 2;
   endfunction
   function automatic int unsigned vec(int s);
      return (s == 0) ? 32'd16 : 32'd8;
   endfunction
   function automatic int ssize(int s);
      return (s == 0) ? stk0.size() : stk1.size();
   endfunction

   task automatic spush(int s, int unsigned v);
      if (s == 0) stk0.push_back(v);
      else        stk1.push_back(v);
   endtask

   task automatic spop(int s, output int unsigned v);
      if (s == 0) v = stk0.pop_back();
      else        v = stk1.pop_back();
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_addr[s] = 0;
         m_halt[s] = 1'b0;
         m_err[s]  = 1'b0;
         m_irqt[s] = 1'b0;
      end
      stk0.delete();
      stk1.delete();
   endtask

   task automatic model_step(int s, logic [2:0] op, int unsigned nad, int unsigned ofs, bit st, bit iq);
      int unsigned a;
      int unsigned mk;
      int unsigned v;
      bit          full;
      a    = m_addr[s];
      mk   = msk(s);
      full = (ssize(s) == dep(s));
      m_irqt[s] = 1'b0;
      if (st) return;
      if (iq && !full) begin
         spush(s, m_halt[s] ? ((a + 1) & mk) : a);
         m_addr[s] = vec(s);
         m_halt[s] = 1'b0;
         m_irqt[s] = 1'b1;
      end else if (!m_halt[s]) begin
         case (op)
            3'd1: m_addr[s] = (a + 1) & mk;
            3'd2: m_addr[s] = nad & mk;
            3'd3: m_addr[s] = (a + ofs) & mk;
            3'd4: begin
               if (full) m_err[s] = 1'b1;
               else begin
                  spush(s, (a + 1) & mk);
                  m_addr[s] = nad & mk;
               end
            end
            3'd5: begin
               if (ssize(s) == 0) m_err[s] = 1'b1;
               else begin
                  spop(s, v);
                  m_addr[s] = v;
               end
            end
            3'd6: m_halt[s] = 1'b1;
            default: ;
         endcase
      end
   endtask

   task automatic push_exp(string tag);
      exp_t e;
      for (int s = 0; s < 2; s++) begin
         e.sel    = s;
         e.addr   = m_addr[s];
         e.halted = m_halt[s];
         e.full   = (ssize(s) == dep(s));
         e.empty  = (ssize(s) == 0);
         e.err    = m_err[s];
         e.irqt   = m_irqt[s];
         e.tag    = tag;
         sb_q.push_back(e);
      end
   endtask

   task automatic check(string tag, int unsigned obs, int unsigned expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drain();
      exp_t        e;
      int unsigned oa;
      while (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         oa = (e.sel == 0) ? int'(addr0) : int'({16'h0, addr1});
         check($sformatf("%s.address[%0d]", e.tag, e.sel), oa, e.addr);
         check($sformatf("%s.halted[%0d]", e.tag, e.sel), int'(halted[e.sel]), int'(e.halted));
         check($sformatf("%s.stackFull[%0d]", e.tag, e.sel), int'(sfull[e.sel]), int'(e.full));
         check($sformatf("%s.stackEmpty[%0d]", e.tag, e.sel), int'(sempty[e.sel]), int'(e.empty));
         check($sformatf("%s.stackError[%0d]", e.tag, e.sel), int'(serr[e.sel]), int'(e.err));
         check($sformatf("%s.irqTaken[%0d]", e.tag, e.sel), int'(irqt[e.sel]), int'(e.irqt));
      end
   endtask

   task automatic idle_inputs();
      op0 = 3'd0; na0 = 20'h0; of0 = 20'h0; stl0 = 1'b0; irq0 = 1'b0;
      op1 = 3'd0; na1 = 4'h0;  of1 = 4'h0;  stl1 = 1'b0; irq1 = 1'b0;
   endtask

   // drive one cycle on instance s, the other instance holds
   task automatic step(int s, logic [2:0] op, logic [19:0] nad, logic [19:0] ofs, bit st, bit iq, string tag);
      idle_inputs();
      if (s == 0) begin
         op0 = op; na0 = nad; of0 = ofs; stl0 = st; irq0 = iq;
      end else begin
         op1 = op; na1 = nad[3:0]; of1 = ofs[3:0]; stl1 = st; irq1 = iq;
      end
      model_step(0, op0, int'(na0), int'(of0), stl0, irq0);
      model_step(1, op1, int'({16'h0, na1}), int'({16'h0, of1}), stl1, irq1);
      push_exp(tag);
      @(posedge clock);
      #1;
      drain();
   endtask

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      push_exp("reset");
      drain();
      reset = 1'b1;

      // counting from reset
      for (int i = 0; i < 5; i++) step(0, 3'd1, 20'h0, 20'h0, 1'b0, 1'b0, "inc");

      // asynchronous reset between clock edges
      op0 = 3'd1;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      push_exp("async_rst");
      drain();
      @(posedge clock);
      #1;
      push_exp("rst_hold");
      drain();
      reset = 1'b1;

      step(0, 3'd7, 20'h0,   20'h0,     1'b0, 1'b0, "rsvd");
      step(0, 3'd2, 20'h10,  20'h0,     1'b0, 1'b0, "jump");
      step(0, 3'd4, 20'h100, 20'h0,     1'b0, 1'b0, "call");
      step(0, 3'd5, 20'h0,   20'h0,     1'b0, 1'b0, "ret");
      step(0, 3'd3, 20'h0,   20'hFFFFD, 1'b0, 1'b0, "branch_neg");
      step(0, 3'd3, 20'h0,   20'h12,    1'b0, 1'b0, "branch_pos");

      // halt and wake by interrupt
      step(0, 3'd6, 20'h0, 20'h0, 1'b0, 1'b0, "halt");
      for (int i = 0; i < 10; i++) step(0, 3'd1, 20'h0, 20'h0, 1'b0, 1'b0, "halt_hold");
      step(0, 3'd1, 20'h0, 20'h0, 1'b0, 1'b1, "irq_halt");
      step(0, 3'd0, 20'h0, 20'h0, 1'b0, 1'b0, "irq_pulse_end");
      step(0, 3'd5, 20'h0, 20'h0, 1'b0, 1'b0, "ret_halt");

      // interrupt blocked by stall, then taken
      for (int i = 0; i < 3; i++) step(0, 3'd1, 20'h0, 20'h0, 1'b1, 1'b1, "stall_irq");
      step(0, 3'd1, 20'h0, 20'h0, 1'b0, 1'b1, "irq_run");
      step(0, 3'd5, 20'h0, 20'h0, 1'b0, 1'b0, "ret_irq");

      // narrow instance: wrap and stack limits
      step(1, 3'd2, 20'hF, 20'h0, 1'b0, 1'b0, "s_jump15");
      step(1, 3'd1, 20'h0, 20'h0, 1'b0, 1'b0, "s_wrap");
      step(1, 3'd3, 20'h0, 20'hE, 1'b0, 1'b0, "s_branch_neg");
      step(1, 3'd2, 20'h3, 20'h0, 1'b0, 1'b0, "s_jump3");
      step(1, 3'd4, 20'h5, 20'h0, 1'b0, 1'b0, "s_call1");
      step(1, 3'd4, 20'h9, 20'h0, 1'b0, 1'b0, "s_call2");
      step(1, 3'd4, 20'h1, 20'h0, 1'b0, 1'b0, "s_call_ovf");
      step(1, 3'd0, 20'h0, 20'h0, 1'b0, 1'b1, "s_irq_full");
      step(1, 3'd5, 20'h0, 20'h0, 1'b0, 1'b1, "s_ret_irq_full");
      step(1, 3'd0, 20'h0, 20'h0, 1'b0, 1'b1, "s_irq_freed");
      step(1, 3'd5, 20'h0, 20'h0, 1'b0, 1'b0, "s_ret_a");
      step(1, 3'd5, 20'h0, 20'h0, 1'b0, 1'b0, "s_ret_b");
      step(1, 3'd5, 20'h0, 20'h0, 1'b0, 1'b0, "s_ret_udf");

      // reset clears the sticky error
      idle_inputs();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      push_exp("final_rst");
      drain();
      @(posedge clock);
      #1;
      reset = 1'b1;
      step(1, 3'd1, 20'h0, 20'h0, 1'b0, 1'b0, "post_rst_inc");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
